// File: rtl/alu_mdu_if.sv
// Request/response bundle for the alu_mdu execute unit.
// The master issues operations and consumes results; the slave is the execute unit.
//   in_valid/in_ready  : request handshake carrying m_op, op, a, b
//   kill               : aborts the in-flight operation
//   out_valid/out_ready: result handshake carrying rslt and zero_flag
//   busy               : unit is iterating a multiply/divide
interface alu_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            m_op;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rslt;
  logic            zero_flag;
  logic            busy;

  modport master (
    output in_valid, m_op, op, a, b, kill, out_ready,
    input  in_ready, out_valid, rslt, zero_flag, busy
  );

  modport slave (
    input  in_valid, m_op, op, a, b, kill, out_ready,
    output in_ready, out_valid, rslt, zero_flag, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute unit: RV base integer ALU ops in one cycle, M-extension mul/div/rem
// iterated one bit per cycle on operand magnitudes with a final sign correction.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mdu_if slave (request, kill, result handshake, busy)
module alu_mdu #(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_mdu_if.slave bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [SHW:0]    CntLoad = (SHW + 1)'(XLEN);
  localparam logic [SHW:0]    CntOne  = (SHW + 1)'(1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [SHW:0]    cnt_q, cnt_d;
  logic [XLEN-1:0] rslt_q, rslt_d;
  logic [XLEN-1:0] hi_q, hi_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;   // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opd_q, opd_d; // multiplicand or divisor magnitude
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;

  logic in_ready, accept;
  assign in_ready = ((state_q == StIdle) | ((state_q == StDone) & bus.out_ready)) & ~bus.kill;
  assign accept   = bus.in_valid & in_ready;

  // Base ALU
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra;
  logic [XLEN-1:0]        base_rslt;
  assign shamt = bus.b[SHW-1:0];
  assign sra   = $signed(bus.a) >>> shamt;

  always_comb begin
    base_rslt = '0;
    case (bus.op[3:1])
      3'b000:  base_rslt = bus.op[0] ? bus.a - bus.b : bus.a + bus.b;
      3'b001:  base_rslt = bus.a << shamt;
      3'b010:  base_rslt = {{(XLEN - 1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      3'b011:  base_rslt = {{(XLEN - 1){1'b0}}, bus.a < bus.b};
      3'b100:  base_rslt = bus.a ^ bus.b;
      3'b101:  base_rslt = bus.op[0] ? sra : bus.a >> shamt;
      3'b110:  base_rslt = bus.a | bus.b;
      default: base_rslt = bus.a & bus.b;
    endcase
  end

  // Operand signs and magnitudes captured at accept
  logic [2:0]      f3_in;
  logic            in_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, corner_rslt;
  assign f3_in    = bus.op[3:1];
  assign in_div   = f3_in[2];
  assign a_sgn    = in_div ? ~f3_in[0] : ((f3_in == 3'b001) | (f3_in == 3'b010));
  assign b_sgn    = in_div ? ~f3_in[0] : (f3_in == 3'b001);
  assign a_neg    = a_sgn & bus.a[XLEN-1];
  assign b_neg    = b_sgn & bus.b[XLEN-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;
  assign div_zero = (bus.b == '0);
  assign div_ovf  = a_sgn & (bus.a == MinNeg) & (bus.b == '1);
  // f3_in[1] distinguishes REM/REMU from DIV/DIVU
  assign corner_rslt = div_zero ? (f3_in[1] ? bus.a : '1) : (f3_in[1] ? '0 : bus.a);

  // One iteration step
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;
  assign mul_sum  = {1'b0, hi_q} + ({1'b0, opd_q} & {(XLEN + 1){lo_q[0]}});
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opd_q};

  always_comb begin
    if (f3_q[2]) begin
      // Restoring divide: keep the trial difference only if it did not go negative
      step_hi = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction applied on the final step's output
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fin_rslt;
  assign prod   = {step_hi, step_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -step_lo : step_lo;
  assign rem    = neg_q ? -step_hi : step_hi;
  always_comb begin
    if (f3_q[2])              fin_rslt = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == '0) fin_rslt = prod_s[XLEN-1:0];
    else                      fin_rslt = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    if (bus.kill && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StCalc: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            rslt_d  = fin_rslt;
            state_d = StDone;
          end
        end
        StDone: if (bus.out_ready) state_d = StIdle;
        default: ;
      endcase
      if (accept) begin
        if (!bus.m_op) begin
          rslt_d  = base_rslt;
          state_d = StDone;
        end else if (in_div && (div_zero || div_ovf)) begin
          rslt_d  = corner_rslt;
          state_d = StDone;
        end else begin
          state_d = StCalc;
          cnt_d   = CntLoad;
          hi_d    = '0;
          f3_d    = f3_in;
          lo_d    = in_div ? a_mag : b_mag;
          opd_d   = in_div ? b_mag : a_mag;
          neg_d   = (in_div && f3_in[1]) ? a_neg : (a_neg ^ b_neg);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rslt_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rslt_q  <= rslt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StCalc);
  assign bus.rslt      = rslt_q;
  assign bus.zero_flag = (rslt_q == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu at XLEN = 32 and XLEN = 16.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel16;
  logic        tv_valid, tv_m, kill, out_ready;
  logic [3:0]  tv_op;
  logic [31:0] tv_a, tv_b;

  always #5 clk = ~clk;

  alu_mdu_if #(.XLEN(32)) if32 ();
  alu_mdu_if #(.XLEN(16)) if16 ();

  assign if32.in_valid  = tv_valid & ~sel16;
  assign if32.m_op      = tv_m;
  assign if32.op        = tv_op;
  assign if32.a         = tv_a;
  assign if32.b         = tv_b;
  assign if32.kill      = kill;
  assign if32.out_ready = out_ready;
  assign if16.in_valid  = tv_valid & sel16;
  assign if16.m_op      = tv_m;
  assign if16.op        = tv_op;
  assign if16.a         = tv_a[15:0];
  assign if16.b         = tv_b[15:0];
  assign if16.kill      = kill;
  assign if16.out_ready = out_ready;

  alu_mdu #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  alu_mdu #(.XLEN(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  logic        rdy, obs_valid, obs_zero, obs_busy;
  logic [31:0] obs_rslt;
  assign rdy       = sel16 ? if16.in_ready  : if32.in_ready;
  assign obs_valid = sel16 ? if16.out_valid : if32.out_valid;
  assign obs_zero  = sel16 ? if16.zero_flag : if32.zero_flag;
  assign obs_busy  = sel16 ? if16.busy      : if32.busy;
  assign obs_rslt  = sel16 ? {16'h0, if16.rslt} : if32.rslt;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          busy_n;
    int          acc;
    int          id;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  busy_cnt = 0;
  int  id_cnt   = 0;
  bit  lat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: latency/busy at first out_valid, result at the output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        busy_cnt = 0;
        check_eq("idle_valid", {31'h0, obs_valid}, 32'h0);
      end else begin
        if (obs_busy) busy_cnt++;
        if (obs_valid && !lat_done) begin
          check_eq($sformatf("latency#%0d", sb[0].id), cyc - sb[0].acc + 1, sb[0].lat);
          check_eq($sformatf("busy_cycles#%0d", sb[0].id), busy_cnt, sb[0].busy_n);
          lat_done = 1'b1;
        end
        if (obs_valid && out_ready) begin
          check_eq($sformatf("rslt#%0d", sb[0].id), obs_rslt, sb[0].exp);
          check_eq($sformatf("zero_flag#%0d", sb[0].id), {31'h0, obs_zero},
                   {31'h0, sb[0].exp == 32'h0});
          void'(sb.pop_front());
          lat_done = 1'b0;
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input bit m, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int bn, input bit push);
    sb_t e;
    bit  ok;
    ok       = 1'b0;
    tv_m     = m;
    tv_op    = op;
    tv_a     = a;
    tv_b     = b;
    tv_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        if (push) begin
          e.exp    = exp;
          e.lat    = lat;
          e.busy_n = bn;
          e.acc    = cyc + 1;
          e.id     = id_cnt;
          id_cnt++;
          sb.push_back(e);
        end
      end
    end
    if (!ok) check_eq("accept_timeout", {31'h0, rdy}, 32'h1);
    else @(posedge clk);
    #1 tv_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 32'h0);
      sb.delete();
      lat_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel16     = 1'b0;
    tv_valid  = 1'b0;
    tv_m      = 1'b0;
    tv_op     = 4'h0;
    tv_a      = '0;
    tv_b      = '0;
    kill      = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    check_eq("rst_out_valid", {31'h0, if32.out_valid}, 32'h0);
    check_eq("rst_busy", {31'h0, if32.busy}, 32'h0);
    check_eq("rst_zero_flag", {31'h0, if32.zero_flag}, 32'h1);
    check_eq("rst_rslt", if32.rslt, 32'h0);
    check_eq("rst_in_ready", {31'h0, if32.in_ready}, 32'h1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Base ops: result valid one cycle after accept
    issue(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1, 0, 1'b1);
    issue(1'b0, 4'b0001, 32'd3, 32'd3, 32'd0, 1, 0, 1'b1);
    issue(1'b0, 4'b1011, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0, 1'b1);
    issue(1'b0, 4'b0110, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 0, 1'b1);
    drain();

    // Multiply
    issue(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 32, 1'b1);
    issue(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 32, 1'b1);
    issue(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, 1'b1);
    issue(1'b1, 4'b0100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 32, 1'b1);
    drain();

    // Divide, including zero divisor and signed overflow
    issue(1'b1, 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 1'b1);
    issue(1'b1, 4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, 1'b1);
    issue(1'b1, 4'b1010, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b1);
    issue(1'b1, 4'b1110, 32'd100, 32'd0, 32'd100, 1, 0, 1'b1);
    issue(1'b1, 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b1);
    issue(1'b1, 4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b1);
    drain();

    // Backpressure then back-to-back accept
    out_ready = 1'b0;
    issue(1'b1, 4'b1000, 32'd100, 32'd7, 32'd14, 33, 32, 1'b1);
    for (int i = 0; i < 100 && !if32.out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_out_valid", {31'h0, if32.out_valid}, 32'h1);
      check_eq("bp_rslt", if32.rslt, 32'd14);
      check_eq("bp_in_ready", {31'h0, if32.in_ready}, 32'h0);
    end
    fork
      issue(1'b0, 4'b0000, 32'd2, 32'd3, 32'd5, 1, 0, 1'b1);
      begin
        @(negedge clk);
        check_eq("b2b_blocked", {31'h0, rdy}, 32'h0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check_eq("b2b_ready", {31'h0, rdy}, 32'h1);
      end
    join
    drain();

    // Kill mid-MULHU; the op must never produce a result
    issue(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check_eq("kill_busy_before", {31'h0, if32.busy}, 32'h1);
    @(posedge clk);
    #1 kill = 1'b0;
    check_eq("kill_busy_after", {31'h0, if32.busy}, 32'h0);
    check_eq("kill_out_valid", {31'h0, if32.out_valid}, 32'h0);
    repeat (40) @(posedge clk);
    #1 kill = 1'b1;
    #1 check_eq("kill_idle_in_ready", {31'h0, if32.in_ready}, 32'h0);
    kill = 1'b0;
    issue(1'b0, 4'b0000, 32'd1, 32'd1, 32'd2, 1, 0, 1'b1);
    drain();

    // Asynchronous reset mid-CALC
    issue(1'b1, 4'b0000, 32'd3, 32'd3, 32'h0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'h0, if32.out_valid}, 32'h0);
    check_eq("arst_zero_flag", {31'h0, if32.zero_flag}, 32'h1);
    check_eq("arst_busy", {31'h0, if32.busy}, 32'h0);
    check_eq("arst_rslt", if32.rslt, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // XLEN = 16 instance
    sel16 = 1'b1;
    issue(1'b1, 4'b0110, 32'hFFFF, 32'hFFFF, 32'hFFFE, 17, 16, 1'b1);
    issue(1'b1, 4'b0000, 32'hFFFF, 32'd2, 32'hFFFE, 17, 16, 1'b1);
    issue(1'b1, 4'b1000, 32'hFFF9, 32'd2, 32'hFFFD, 17, 16, 1'b1);
    issue(1'b1, 4'b1100, 32'hFFF9, 32'd2, 32'hFFFF, 17, 16, 1'b1);
    issue(1'b1, 4'b1010, 32'd100, 32'd0, 32'hFFFF, 1, 0, 1'b1);
    issue(1'b1, 4'b1100, 32'h8000, 32'hFFFF, 32'h0, 1, 0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
